// File: rtl/updown_counter.sv
// Up/down modulo counter with prescaled clock enable, optional saturation at the
// bounds, synchronous parallel load, and registered tick / terminal / sticky wrap
// status outputs.
module updown_counter #(
    parameter int unsigned Size     = 5,
    parameter int unsigned Modulus  = 32,
    parameter int unsigned Prescale = 1,
    parameter bit          Saturate = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    input  logic            clear_wrap,
    output logic [Size-1:0] count,
    output logic            tick,
    output logic            terminal,
    output logic            wrapped
);

    // A single-stage prescaler still needs a 1-bit register to stay legal.
    localparam int unsigned PsW = (Prescale > 1) ? $clog2(Prescale) : 1;

    localparam logic [PsW-1:0]  PsMax  = PsW'(Prescale - 1);
    localparam logic [Size-1:0] MaxVal = Size'(Modulus - 1);
    localparam logic [Size-1:0] MinVal = '0;

    // Modulus may equal 2**Size, so the load bound needs one extra bit.
    localparam logic [Size:0] LoadLimit = (Size + 1)'(Modulus);

    logic [Size-1:0] count_q, count_d;
    logic [PsW-1:0]  ps_q, ps_d;
    logic            tick_q, tick_d;
    logic            terminal_q, terminal_d;
    logic            wrapped_q, wrapped_d;

    logic            at_max;
    logic            at_min;
    logic            step;
    logic            bound_hit;
    logic [Size-1:0] load_clamped;
    logic [Size-1:0] step_value;

    // Decode the step condition, the bound hit and the candidate next count.
    always_comb begin
        at_max       = (count_q == MaxVal);
        at_min       = (count_q == MinVal);
        step         = enable && (ps_q == PsMax);
        bound_hit    = step && (up ? at_max : at_min);
        load_clamped = ({1'b0, load_value} < LoadLimit) ? load_value : MaxVal;

        step_value = count_q;
        if (up) begin
            if (at_max) begin
                step_value = Saturate ? MaxVal : MinVal;
            end else begin
                step_value = count_q + Size'(1);
            end
        end else begin
            if (at_min) begin
                step_value = Saturate ? MinVal : MaxVal;
            end else begin
                step_value = count_q - Size'(1);
            end
        end
    end

    // Next-state: load outranks stepping; enable low freezes count and prescaler.
    always_comb begin
        count_d    = count_q;
        ps_d       = ps_q;
        tick_d     = 1'b0;
        terminal_d = 1'b0;
        wrapped_d  = wrapped_q;

        if (load) begin
            count_d = load_clamped;
            ps_d    = '0;
        end else begin
            if (enable) begin
                if (step) begin
                    ps_d       = '0;
                    count_d    = step_value;
                    tick_d     = 1'b1;
                    terminal_d = bound_hit;
                end else begin
                    ps_d = ps_q + PsW'(1);
                end
            end
            // A bound hit in the same cycle as clear_wrap keeps the flag set.
            if (bound_hit) begin
                wrapped_d = 1'b1;
            end else if (clear_wrap) begin
                wrapped_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            ps_q       <= '0;
            tick_q     <= 1'b0;
            terminal_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            ps_q       <= ps_d;
            tick_q     <= tick_d;
            terminal_q <= terminal_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign terminal = terminal_q;
    assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (wrap/P1, saturate/P1, wrap/P3) share
// one stimulus stream and are checked every cycle against a behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_updown_counter;

    localparam int Size    = 5;
    localparam int Modulus = 10;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            up;
    logic            load;
    logic [Size-1:0] load_value;
    logic            clear_wrap;

    logic [Size-1:0] count_a, count_b, count_c;
    logic            tick_a, tick_b, tick_c;
    logic            term_a, term_b, term_c;
    logic            wr_a, wr_b, wr_c;

    always #5 clock = ~clock;

    updown_counter #(.Size(Size), .Modulus(Modulus), .Prescale(1), .Saturate(1'b0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear_wrap(clear_wrap),
        .count(count_a), .tick(tick_a), .terminal(term_a), .wrapped(wr_a)
    );

    updown_counter #(.Size(Size), .Modulus(Modulus), .Prescale(1), .Saturate(1'b1)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear_wrap(clear_wrap),
        .count(count_b), .tick(tick_b), .terminal(term_b), .wrapped(wr_b)
    );

    updown_counter #(.Size(Size), .Modulus(Modulus), .Prescale(3), .Saturate(1'b0)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear_wrap(clear_wrap),
        .count(count_c), .tick(tick_c), .terminal(term_c), .wrapped(wr_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state per instance.
    int cfg_p[3] = '{1, 1, 3};
    bit cfg_s[3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt[3];
    int m_ps[3];
    bit m_tick[3];
    bit m_term[3];
    bit m_wr[3];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_update(input int i);
        bit stepped;
        bit hit;
        if (reset) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_tick[i] = 0; m_term[i] = 0; m_wr[i] = 0;
        end else if (load) begin
            m_cnt[i]  = (int'(load_value) < Modulus) ? int'(load_value) : Modulus - 1;
            m_ps[i]   = 0;
            m_tick[i] = 0;
            m_term[i] = 0;
        end else begin
            stepped = 0;
            hit     = 0;
            if (enable) begin
                m_ps[i] = m_ps[i] + 1;
                if (m_ps[i] == cfg_p[i]) begin
                    m_ps[i] = 0;
                    stepped = 1;
                    if (up) begin
                        hit = (m_cnt[i] == Modulus - 1);
                        if (hit) m_cnt[i] = cfg_s[i] ? Modulus - 1 : 0;
                        else     m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        hit = (m_cnt[i] == 0);
                        if (hit) m_cnt[i] = cfg_s[i] ? 0 : Modulus - 1;
                        else     m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
            m_tick[i] = stepped;
            m_term[i] = hit;
            if (hit) m_wr[i] = 1;
            else if (clear_wrap) m_wr[i] = 0;
        end
    endfunction

    task automatic compare_all();
        check("a.count",    int'(count_a), m_cnt[0]);
        check("a.tick",     int'(tick_a),  int'(m_tick[0]));
        check("a.terminal", int'(term_a),  int'(m_term[0]));
        check("a.wrapped",  int'(wr_a),    int'(m_wr[0]));
        check("b.count",    int'(count_b), m_cnt[1]);
        check("b.tick",     int'(tick_b),  int'(m_tick[1]));
        check("b.terminal", int'(term_b),  int'(m_term[1]));
        check("b.wrapped",  int'(wr_b),    int'(m_wr[1]));
        check("c.count",    int'(count_c), m_cnt[2]);
        check("c.tick",     int'(tick_c),  int'(m_tick[2]));
        check("c.terminal", int'(term_c),  int'(m_term[2]));
        check("c.wrapped",  int'(wr_c),    int'(m_wr[2]));
    endtask

    // One clock: advance the model on the sampled inputs, then compare after the edge.
    task automatic cycle();
        for (int i = 0; i < 3; i++) model_update(i);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 0; enable = 0; up = 1; load = 0; load_value = '0; clear_wrap = 0;
    endtask

    int en_pat[11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        idle();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_tick[i] = 0; m_term[i] = 0; m_wr[i] = 0;
        end

        // Reset state.
        reset = 1;
        cycle();
        cycle();
        check("reset count_a", int'(count_a), 0);
        check("reset wrapped_c", int'(wr_c), 0);

        // Scenario 1: count up 10 steps, wrap to 0 on the tenth.
        idle();
        enable = 1;
        up = 1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("s1 count_a", int'(count_a), k % 10);
            check("s1 terminal_a", int'(term_a), (k == 10) ? 1 : 0);
        end
        check("s1 wrapped_a", int'(wr_a), 1);
        check("s1 sat count_b", int'(count_b), 9);

        // Scenario 2: down from 0 wraps to 9; clear_wrap loses to a coincident hit.
        up = 0;
        cycle();
        check("s2 count_a", int'(count_a), 9);
        check("s2 terminal_a", int'(term_a), 1);
        check("s2 tick_a", int'(tick_a), 1);
        up = 1;
        clear_wrap = 1;
        cycle();
        check("s2 count_a wrap", int'(count_a), 0);
        check("s2 wrapped_a kept", int'(wr_a), 1);
        clear_wrap = 1;
        enable = 0;
        cycle();
        check("s2 wrapped_a cleared", int'(wr_a), 0);
        check("s2 tick_a idle", int'(tick_a), 0);

        // Scenario 3: saturating instance holds at both bounds.
        idle();
        load = 1;
        load_value = 9;
        cycle();
        load = 0;
        enable = 1;
        up = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("s3 count_b hold", int'(count_b), 9);
            check("s3 terminal_b", int'(term_b), 1);
        end
        enable = 0;
        load = 1;
        load_value = 0;
        cycle();
        load = 0;
        enable = 1;
        up = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("s3 count_b floor", int'(count_b), 0);
            check("s3 terminal_b floor", int'(term_b), 1);
        end

        // Scenario 4: Prescale=3, enable gaps do not restart the prescaler.
        idle();
        reset = 1;
        cycle();
        reset = 0;
        up = 1;
        for (int k = 0; k < 11; k++) begin
            enable = en_pat[k][0];
            // Toggle direction off the step cycles; only the step-cycle value matters.
            up = (k == 4 || k == 7 || k == 10) ? 1'b1 : 1'b0;
            cycle();
            check("s4 tick_c", int'(tick_c), (k == 4 || k == 7 || k == 10) ? 1 : 0);
        end
        check("s4 count_c", int'(count_c), 3);

        // Scenario 5: load clamps, and load beats enable.
        idle();
        load = 1;
        load_value = 15;
        cycle();
        check("s5 clamp count_a", int'(count_a), 9);
        check("s5 clamp count_c", int'(count_c), 9);
        load_value = 4;
        enable = 1;
        cycle();
        check("s5 load+en count_a", int'(count_a), 4);
        check("s5 load+en tick_a", int'(tick_a), 0);

        // Scenario 6: reset mid-prescale restarts the prescaler.
        idle();
        load = 1;
        load_value = 9;
        cycle();
        load = 0;
        enable = 1;
        up = 1;
        for (int k = 0; k < 3; k++) cycle();
        check("s6 wrapped_c set", int'(wr_c), 1);
        load = 1;
        load_value = 7;
        enable = 0;
        cycle();
        load = 0;
        enable = 1;
        cycle();
        cycle();
        check("s6 count_c pre", int'(count_c), 7);
        reset = 1;
        cycle();
        check("s6 reset count_c", int'(count_c), 0);
        check("s6 reset wrapped_c", int'(wr_c), 0);
        reset = 0;
        cycle();
        cycle();
        check("s6 no early step", int'(count_c), 0);
        cycle();
        check("s6 third step count_c", int'(count_c), 1);
        check("s6 third step tick_c", int'(tick_c), 1);

        // Randomised traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            reset      = ($urandom_range(63) == 0);
            load       = ($urandom_range(15) == 0);
            enable     = ($urandom_range(3) != 0);
            up         = $urandom_range(1) == 1;
            clear_wrap = ($urandom_range(7) == 0);
            load_value = Size'($urandom_range(31));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
